// File: rtl/pr_led_sequencer.sv
// pr_led_sequencer: isolates the LED partition, requests a PR load, waits for done/error/timeout, then holds the new module in reset
module pr_led_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 33554431
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [1:0] trig_sel,
  output logic       pr_req,
  output logic [1:0] pr_sel,
  input  logic       pr_done,
  input  logic       pr_err,
  input  logic [3:0] rm_leds,
  output logic [3:0] leds,
  output logic       decouple,
  output logic       rm_rst,
  output logic [1:0] active_sel,
  output logic       busy,
  output logic       err
);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_REQ, S_RESET, S_ERROR} state_t;
  localparam logic [24:0] L_SET = 25'(SETTLE_CYCLES - 1);
  localparam logic [24:0] L_RST = 25'(RST_CYCLES - 1);
  localparam logic [24:0] L_TO = 25'(TIMEOUT_CYCLES - 1);
  state_t r_state;
  logic [24:0] r_cnt;
  logic r_trig;
  logic w_go;
  assign w_go = trig & ~r_trig & (trig_sel != 2'd3);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RESET;
      r_cnt <= '0;
      r_trig <= 1'b0;
      pr_req <= 1'b0;
      pr_sel <= 2'd0;
      leds <= 4'd0;
      decouple <= 1'b0;
      rm_rst <= 1'b1;
      active_sel <= 2'd0;
      busy <= 1'b1;
      err <= 1'b0;
    end else begin
      r_trig <= trig;
      if (!decouple) leds <= rm_leds;
      case (r_state)
        S_IDLE, S_ERROR: if (w_go) begin
          r_state <= S_SETTLE;
          r_cnt <= '0;
          pr_sel <= trig_sel;
          decouple <= 1'b1;
          busy <= 1'b1;
        end
        S_SETTLE: if (r_cnt == L_SET) begin
          r_state <= S_REQ;
          r_cnt <= '0;
          pr_req <= 1'b1;
        end else r_cnt <= r_cnt + 25'd1;
        S_REQ: if (pr_err || r_cnt == L_TO) begin
          r_state <= S_ERROR;
          pr_req <= 1'b0;
          err <= 1'b1;
          rm_rst <= 1'b1;
          leds <= 4'hf;
          busy <= 1'b0;
        end else if (pr_done) begin
          r_state <= S_RESET;
          r_cnt <= '0;
          pr_req <= 1'b0;
          active_sel <= pr_sel;
          err <= 1'b0;
          rm_rst <= 1'b1;
        end else r_cnt <= r_cnt + 25'd1;
        S_RESET: if (r_cnt == L_RST) begin
          r_state <= S_IDLE;
          rm_rst <= 1'b0;
          decouple <= 1'b0;
          busy <= 1'b0;
        end else r_cnt <= r_cnt + 25'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pr_led_sequencer.sv
// tb_pr_led_sequencer: scoreboard bench comparing every output change against hand-computed cycle/value events
module tb_pr_led_sequencer;
  logic clk = 1'b0;
  logic rst, trig, pr_done, pr_err;
  logic [1:0] trig_sel, pr_sel, active_sel;
  logic [3:0] rm_leds, leds;
  logic pr_req, decouple, rm_rst, busy, err;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic first = 1'b1;
  logic [12:0] cur, prev;
  typedef struct {
    int cyc;
    logic [12:0] v;
  } ev_t;
  ev_t q[$];
  ev_t e;
  pr_led_sequencer #(.SETTLE_CYCLES(4), .RST_CYCLES(16), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .trig(trig), .trig_sel(trig_sel), .pr_req(pr_req), .pr_sel(pr_sel),
    .pr_done(pr_done), .pr_err(pr_err), .rm_leds(rm_leds), .leds(leds), .decouple(decouple),
    .rm_rst(rm_rst), .active_sel(active_sel), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic ex(input int c, input logic r, input logic [1:0] s, input logic [3:0] l, input logic d,
                    input logic m, input logic [1:0] a, input logic b, input logic x);
    ev_t n;
    n.cyc = c;
    n.v = {r, s, l, d, m, a, b, x};
    q.push_back(n);
  endtask
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      cur = {pr_req, pr_sel, leds, decouple, rm_rst, active_sel, busy, err};
      if (first || cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got {req,sel,leds,dec,rmrst,asel,busy,err}=%b", cyc, cur);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || cur !== e.v) begin
            errors++;
            $display("FAIL event got cyc=%0d val=%b, required cyc=%0d val=%b", cyc, cur, e.cyc, e.v);
          end
        end
      end
      prev = cur;
      first = 1'b0;
    end
  end
  initial begin
    rst = 1'b1; trig = 1'b0; trig_sel = 2'd0; pr_done = 1'b0; pr_err = 1'b0; rm_leds = 4'h0;
    at(3);
    ex(3, 0, 0, 4'h0, 0, 1, 0, 1, 0);
    ex(19, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    rst = 1'b0;
    at(20); rm_leds = 4'h3;
    ex(21, 0, 0, 4'h3, 0, 0, 0, 0, 0);
    at(22); trig = 1'b1; trig_sel = 2'd1;
    ex(23, 0, 1, 4'h3, 1, 0, 0, 1, 0);
    ex(27, 1, 1, 4'h3, 1, 0, 0, 1, 0);
    ex(38, 0, 1, 4'h3, 1, 1, 1, 1, 0);
    ex(54, 0, 1, 4'h3, 0, 0, 1, 0, 0);
    ex(55, 0, 1, 4'hc, 0, 0, 1, 0, 0);
    at(23); trig = 1'b0; rm_leds = 4'hc;
    at(30); trig = 1'b1; trig_sel = 2'd2;
    at(31); trig = 1'b0;
    at(37); pr_done = 1'b1;
    at(38); pr_done = 1'b0;
    at(60); trig = 1'b1; trig_sel = 2'd3;
    at(61); trig = 1'b0;
    at(62); pr_done = 1'b1;
    at(63); pr_done = 1'b0;
    at(65); trig = 1'b1; trig_sel = 2'd2;
    ex(66, 0, 2, 4'hc, 1, 0, 1, 1, 0);
    ex(70, 1, 2, 4'hc, 1, 0, 1, 1, 0);
    ex(74, 0, 2, 4'hf, 1, 1, 1, 0, 1);
    at(66); trig = 1'b0;
    at(73); pr_err = 1'b1;
    at(74); pr_err = 1'b0;
    at(78); pr_done = 1'b1;
    at(79); pr_done = 1'b0;
    at(80); trig = 1'b1; trig_sel = 2'd0;
    ex(81, 0, 0, 4'hf, 1, 1, 1, 1, 1);
    ex(85, 1, 0, 4'hf, 1, 1, 1, 1, 1);
    ex(91, 0, 0, 4'hf, 1, 1, 0, 1, 0);
    ex(107, 0, 0, 4'hf, 0, 0, 0, 0, 0);
    ex(108, 0, 0, 4'hc, 0, 0, 0, 0, 0);
    at(81); trig = 1'b0;
    at(90); pr_done = 1'b1;
    at(91); pr_done = 1'b0;
    at(112); trig = 1'b1; trig_sel = 2'd1;
    ex(113, 0, 1, 4'hc, 1, 0, 0, 1, 0);
    ex(117, 1, 1, 4'hc, 1, 0, 0, 1, 0);
    ex(217, 0, 1, 4'hf, 1, 1, 0, 0, 1);
    at(113); trig = 1'b0;
    at(222); trig = 1'b1; trig_sel = 2'd2;
    ex(223, 0, 2, 4'hf, 1, 1, 0, 1, 1);
    ex(227, 1, 2, 4'hf, 1, 1, 0, 1, 1);
    ex(231, 0, 2, 4'hf, 1, 1, 0, 0, 1);
    at(223); trig = 1'b0;
    at(230); pr_done = 1'b1; pr_err = 1'b1;
    at(231); pr_done = 1'b0; pr_err = 1'b0;
    at(235); trig = 1'b1; trig_sel = 2'd1;
    ex(236, 0, 1, 4'hf, 1, 1, 0, 1, 1);
    ex(240, 1, 1, 4'hf, 1, 1, 0, 1, 1);
    ex(244, 0, 0, 4'h0, 0, 1, 0, 1, 0);
    ex(245, 0, 0, 4'hc, 0, 1, 0, 1, 0);
    ex(260, 0, 0, 4'hc, 0, 0, 0, 0, 0);
    at(236); trig = 1'b0;
    at(243); rst = 1'b1;
    at(244); rst = 1'b0;
    at(275);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d pending, required 0 (next cyc=%0d)", q.size(), q[0].cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
